// File: rtl/score_keeper_if.sv
// score_keeper_if: frame tick, start button and ball position into the
// scoring controller, with scores and game status back out.
interface score_keeper_if;
   logic       refresh_tick;
   logic       start;
   logic [9:0] ball_x;
   logic       ball_rst;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       point1;
   logic       point2;
   logic       game_active;
   logic       game_over;
   logic       winner;

   modport master (
      output refresh_tick, start, ball_x,
      input  ball_rst, score1, score2, point1, point2,
             game_active, game_over, winner
   );

   modport slave (
      input  refresh_tick, start, ball_x,
      output ball_rst, score1, score2, point1, point2,
             game_active, game_over, winner
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: rally/scoring controller behind the ball mover. Watches the
// ball on each frame tick, awards points on a miss, runs the serve delay with
// the ball mover held in reset, and parks in GAME_OVER at the winning score.
module score_keeper #(
   parameter int WIN_SCORE   = 9,
   parameter int LEFT_LIMIT  = 8,
   parameter int RIGHT_LIMIT = 632,
   parameter int WRAP_LIMIT  = 960,
   parameter int SERVE_DELAY = 60
) (
   input  logic          clk,
   input  logic          reset_n,
   score_keeper_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

   localparam logic [9:0] LEFT_L  = 10'(LEFT_LIMIT);
   localparam logic [9:0] RIGHT_L = 10'(RIGHT_LIMIT);
   localparam logic [9:0] WRAP_L  = 10'(WRAP_LIMIT);
   localparam logic [3:0] WIN     = 4'(WIN_SCORE);
   localparam logic [7:0] SD      = 8'(SERVE_DELAY);

   state_t     state_q, state_d;
   logic       start_q;
   logic       start_edge;
   logic [7:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0] score1_q, score1_d, score1_inc;
   logic [3:0] score2_q, score2_d, score2_inc;
   logic       winner_q, winner_d;
   logic       point1_q, point1_d;
   logic       point2_q, point2_d;
   logic       ball_rst_q, game_active_q, game_over_q;
   logic       miss_left, miss_right;

   // A ball past the wrap limit has run off the left edge and wrapped round.
   assign miss_left  = (bus.ball_x < LEFT_L) || (bus.ball_x >= WRAP_L);
   assign miss_right = (bus.ball_x >= RIGHT_L) && (bus.ball_x < WRAP_L);
   assign start_edge = bus.start & ~start_q;
   assign cnt_inc    = cnt_q + 8'd1;
   assign score1_inc = score1_q + 4'd1;
   assign score2_inc = score2_q + 4'd1;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state, scoring and serve-counter decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      point1_d = 1'b0;
      point2_d = 1'b0;
      case (state_q)
         IDLE, GAME_OVER: begin
            // A tick coinciding with the start edge is deliberately not counted.
            if (start_edge) begin
               score1_d = 4'd0;
               score2_d = 4'd0;
               winner_d = 1'b0;
               cnt_d    = 8'd0;
               state_d  = SERVE;
            end
         end
         SERVE: begin
            if (bus.refresh_tick) begin
               if (cnt_inc == SD) begin
                  cnt_d   = 8'd0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         PLAY: begin
            if (bus.refresh_tick) begin
               if (miss_left) begin
                  score2_d = score2_inc;
                  point2_d = 1'b1;
                  cnt_d    = 8'd0;
                  if (score2_inc == WIN) begin
                     winner_d = 1'b1;
                     state_d  = GAME_OVER;
                  end else begin
                     state_d = SERVE;
                  end
               end else if (miss_right) begin
                  score1_d = score1_inc;
                  point1_d = 1'b1;
                  cnt_d    = 8'd0;
                  if (score1_inc == WIN) begin
                     winner_d = 1'b0;
                     state_d  = GAME_OVER;
                  end else begin
                     state_d = SERVE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers and registered status outputs derived from next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q       <= 1'b0;
         cnt_q         <= 8'd0;
         score1_q      <= 4'd0;
         score2_q      <= 4'd0;
         winner_q      <= 1'b0;
         point1_q      <= 1'b0;
         point2_q      <= 1'b0;
         ball_rst_q    <= 1'b1;
         game_active_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         start_q       <= bus.start;
         cnt_q         <= cnt_d;
         score1_q      <= score1_d;
         score2_q      <= score2_d;
         winner_q      <= winner_d;
         point1_q      <= point1_d;
         point2_q      <= point2_d;
         ball_rst_q    <= (state_d != PLAY);
         game_active_q <= (state_d == SERVE) || (state_d == PLAY);
         game_over_q   <= (state_d == GAME_OVER);
      end
   end

   assign bus.ball_rst    = ball_rst_q;
   assign bus.score1      = score1_q;
   assign bus.score2      = score2_q;
   assign bus.point1      = point1_q;
   assign bus.point2      = point2_q;
   assign bus.game_active = game_active_q;
   assign bus.game_over   = game_over_q;
   assign bus.winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus with hand-computed expectations queued
// per cycle; a monitor pops and compares them against the registered outputs.
module tb_score_keeper;

   localparam int SD = 60;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          cyc;
      string       name;
      logic [13:0] vec;
   } exp_t;

   exp_t q[$];

   score_keeper_if sk();

   score_keeper dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sk)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [13:0] act_vec();
      return {sk.score1, sk.score2, sk.point1, sk.point2, sk.ball_rst,
              sk.game_active, sk.game_over, sk.winner};
   endfunction

   function automatic logic [13:0] mk(input logic [3:0] s1, input logic [3:0] s2,
                                      input logic p1, input logic p2, input logic br,
                                      input logic ga, input logic go, input logic w);
      return {s1, s2, p1, p2, br, ga, go, w};
   endfunction

   task automatic chk(input string name, input logic [13:0] want);
      logic [13:0] got;
      got = act_vec();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s @cyc %0d: got s1=%0d s2=%0d p1p2=%b%b rst=%b act=%b over=%b win=%b, want s1=%0d s2=%0d p1p2=%b%b rst=%b act=%b over=%b win=%b",
                  name, cyc, got[13:10], got[9:6], got[5], got[4], got[3], got[2], got[1], got[0],
                  want[13:10], want[9:6], want[5], want[4], want[3], want[2], want[1], want[0]);
      end
   endtask

   // Monitor: compare every expectation due this cycle; any point pulse
   // without a matching expectation is a spurious score.
   initial begin
      exp_t e;
      logic matched;
      forever begin
         @(negedge clk);
         matched = 1'b0;
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc == cyc) matched = 1'b1;
            chk(e.name, e.vec);
         end
         if ((sk.point1 | sk.point2) && !matched) begin
            total++;
            bad++;
            $display("FAIL spurious_point @cyc %0d: got point1=%b point2=%b, want 0 0",
                     cyc, sk.point1, sk.point2);
         end
      end
   end

   task automatic drive(input logic tk, input logic st, input logic [9:0] bx);
      @(negedge clk);
      sk.refresh_tick = tk;
      sk.start        = st;
      sk.ball_x       = bx;
   endtask

   task automatic expect_next(input string name, input logic [3:0] s1, input logic [3:0] s2,
                              input logic p1, input logic p2, input logic br,
                              input logic ga, input logic go, input logic w);
      exp_t e;
      e.cyc  = cyc + 1;
      e.name = name;
      e.vec  = mk(s1, s2, p1, p2, br, ga, go, w);
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'd320);
   endtask

   // Full serve with ticks 3 cycles apart; ball_rst must still be high after
   // tick SD-1 and fall right after tick SD.
   task automatic serve(input logic [3:0] s1, input logic [3:0] s2);
      for (int i = 1; i <= SD; i++) begin
         drive(1'b1, 1'b0, 10'd320);
         if (i == SD - 1) expect_next("serve_wait", s1, s2, 0, 0, 1, 1, 0, 0);
         if (i == SD)     expect_next("serve_done", s1, s2, 0, 0, 0, 1, 0, 0);
         idle(2);
      end
   endtask

   initial begin
      logic [9:0] g2_bx [7];
      logic [3:0] g2_s1 [7];
      logic [3:0] g2_s2 [7];
      g2_bx = '{10'd5, 10'd640, 10'd5, 10'd640, 10'd5, 10'd640, 10'd5};
      g2_s1 = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
      g2_s2 = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4};

      reset_n         = 1'b0;
      sk.refresh_tick = 1'b0;
      sk.start        = 1'b0;
      sk.ball_x       = 10'd320;
      repeat (3) @(negedge clk);
      chk("reset_vals", mk(0, 0, 0, 0, 1, 0, 0, 0));
      reset_n = 1'b1;

      // Game 1
      drive(1'b1, 1'b0, 10'd5);
      expect_next("idle_no_start", 0, 0, 0, 0, 1, 0, 0, 0);
      drive(1'b0, 1'b1, 10'd320);
      expect_next("start_serve", 0, 0, 0, 0, 1, 1, 0, 0);
      idle(2);
      serve(0, 0);

      drive(1'b1, 1'b0, 10'd5);
      expect_next("left_miss", 0, 1, 0, 1, 1, 1, 0, 0);
      drive(1'b0, 1'b0, 10'd320);
      expect_next("point2_clear", 0, 1, 0, 0, 1, 1, 0, 0);
      idle(1);
      serve(0, 1);

      drive(1'b1, 1'b0, 10'd1020);
      expect_next("wrap_miss", 0, 2, 0, 1, 1, 1, 0, 0);
      idle(2);
      serve(0, 2);

      drive(1'b0, 1'b1, 10'd320);
      expect_next("start_in_play", 0, 2, 0, 0, 0, 1, 0, 0);
      idle(2);

      drive(1'b1, 1'b0, 10'd640);
      expect_next("right_miss", 1, 2, 1, 0, 1, 1, 0, 0);
      idle(2);
      serve(1, 2);

      drive(1'b1, 1'b0, 10'd320);
      expect_next("no_miss_320", 1, 2, 0, 0, 0, 1, 0, 0);
      idle(2);
      drive(1'b1, 1'b0, 10'd8);
      expect_next("no_miss_8", 1, 2, 0, 0, 0, 1, 0, 0);
      idle(2);
      drive(1'b1, 1'b0, 10'd631);
      expect_next("no_miss_631", 1, 2, 0, 0, 0, 1, 0, 0);
      idle(2);
      drive(1'b1, 1'b0, 10'd632);
      expect_next("right_miss_632", 2, 2, 1, 0, 1, 1, 0, 0);
      idle(2);
      serve(2, 2);
      drive(1'b1, 1'b0, 10'd959);
      expect_next("right_miss_959", 3, 2, 1, 0, 1, 1, 0, 0);
      idle(2);
      serve(3, 2);
      drive(1'b1, 1'b0, 10'd960);
      expect_next("left_miss_960", 3, 3, 0, 1, 1, 1, 0, 0);
      idle(2);
      serve(3, 3);

      for (int s = 4; s <= 8; s++) begin
         drive(1'b1, 1'b0, 10'd640);
         expect_next("p1_run", 4'(s), 3, 1, 0, 1, 1, 0, 0);
         idle(2);
         serve(4'(s), 3);
      end
      drive(1'b1, 1'b0, 10'd640);
      expect_next("win_p1", 9, 3, 1, 0, 1, 0, 1, 0);
      drive(1'b0, 1'b0, 10'd320);
      expect_next("win_p1_hold", 9, 3, 0, 0, 1, 0, 1, 0);
      idle(1);
      drive(1'b1, 1'b0, 10'd5);
      expect_next("go_tick_left", 9, 3, 0, 0, 1, 0, 1, 0);
      idle(2);
      drive(1'b1, 1'b0, 10'd640);
      expect_next("go_tick_right", 9, 3, 0, 0, 1, 0, 1, 0);
      idle(2);

      // Restart from GAME_OVER with a coinciding tick that must not count.
      drive(1'b1, 1'b1, 10'd320);
      expect_next("restart", 0, 0, 0, 0, 1, 1, 0, 0);
      idle(2);
      serve(0, 0);

      // Game 2: reach 3/4, then async reset mid-PLAY
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, g2_bx[i]);
         expect_next("g2_point", g2_s1[i], g2_s2[i], g2_bx[i] == 10'd640, g2_bx[i] == 10'd5,
                     1, 1, 0, 0);
         idle(2);
         serve(g2_s1[i], g2_s2[i]);
      end
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk("async_rst", mk(0, 0, 0, 0, 1, 0, 0, 0));
      drive(1'b1, 1'b0, 10'd5);
      expect_next("in_reset", 0, 0, 0, 0, 1, 0, 0, 0);
      idle(2);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 10'd640);
      expect_next("idle_after_rst", 0, 0, 0, 0, 1, 0, 0, 0);
      idle(3);
      expect_next("idle_still", 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);

      // Start held through reset release: exactly one edge, tick ignored.
      reset_n = 1'b0;
      drive(1'b0, 1'b1, 10'd320);
      drive(1'b0, 1'b1, 10'd320);
      drive(1'b1, 1'b1, 10'd320);
      reset_n = 1'b1;
      expect_next("start_thru_rst", 0, 0, 0, 0, 1, 1, 0, 0);
      drive(1'b0, 1'b1, 10'd320);
      idle(1);
      serve(0, 0);

      // Game 3: player 2 wins
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 1'b0, 10'd5);
         if (i < 9) begin
            expect_next("p2_run", 0, 4'(i), 0, 1, 1, 1, 0, 0);
            idle(2);
            serve(0, 4'(i));
         end else begin
            expect_next("win_p2", 0, 9, 0, 1, 1, 0, 1, 1);
         end
      end
      drive(1'b0, 1'b0, 10'd320);
      expect_next("win_p2_hold", 0, 9, 0, 0, 1, 0, 1, 1);
      idle(3);

      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL queue_drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
